// File: rtl/vpu_lane_seq.sv
// Vector issue sequencer: streams fp16 element pairs of one instruction into
// LANES combinational ALU lanes and assembles the lane results into one response.
module vpu_lane_seq #(
   parameter int LANES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   // Handshakes: a transfer happens on a rising edge where valid && ready.
   // req_ready is high only in IDLE. rsp_valid stays high in DONE, and rsp_vd
   // and rsp_mask do not change, until rsp_ready is seen.
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_func,
   input  logic [3:0]            req_len,
   input  logic [127:0]          req_vs1,
   input  logic [127:0]          req_vs2,
   output logic                  alu_enable,
   output logic                  alu_addsel,
   output logic                  alu_subsel,
   output logic                  alu_mulsel,
   output logic                  alu_itfsel,
   output logic                  alu_ftisel,
   output logic                  alu_maxsel,
   output logic                  alu_minsel,
   output logic [16*LANES-1:0]   alu_op1,
   output logic [16*LANES-1:0]   alu_op2,
   input  logic [16*LANES-1:0]   alu_opout,
   input  logic [LANES-1:0]      alu_gt,
   input  logic [LANES-1:0]      alu_eq,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [127:0]          rsp_vd,
   output logic [7:0]            rsp_mask,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [3:0] F_ADD   = 4'd1;
   localparam logic [3:0] F_SUB   = 4'd2;
   localparam logic [3:0] F_MUL   = 4'd3;
   localparam logic [3:0] F_ITF   = 4'd4;
   localparam logic [3:0] F_FTI   = 4'd5;
   localparam logic [3:0] F_MAX   = 4'd6;
   localparam logic [3:0] F_MIN   = 4'd7;
   localparam logic [3:0] F_CMPGT = 4'd8;
   localparam logic [3:0] F_CMPEQ = 4'd9;

   localparam logic [4:0] STEP5 = 5'(LANES);
   localparam logic [3:0] STEP4 = 4'(LANES);

   state_t         state;
   state_t         state_nxt;
   logic [3:0]     idx;
   logic [3:0]     len_q;
   logic [3:0]     func_q;
   logic [127:0]   vs1_q;
   logic [127:0]   vs2_q;
   logic [127:0]   vd_q;
   logic [7:0]     mask_q;

   logic [3:0]     eff_len;
   logic           last_beat;
   logic [4:0]     lane_pos  [LANES];
   logic [2:0]     lane_elem [LANES];
   logic [LANES-1:0] lane_live;

   // 0 encodes a full vector; anything past 8 saturates.
   always_comb begin
      eff_len = req_len;
      if (req_len == 4'd0 || req_len > 4'd8) begin
         eff_len = 4'd8;
      end
   end

   // Element index each lane works on this cycle, and whether it is inside N.
   // idx is always a multiple of LANES below N, so lane_pos never leaves 0..7
   // while issuing.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         lane_pos[j]  = {1'b0, idx} + 5'(j);
         lane_elem[j] = lane_pos[j][2:0];
         lane_live[j] = lane_pos[j] < {1'b0, len_q};
      end
   end

   assign last_beat = ({1'b0, idx} + STEP5) >= {1'b0, len_q};

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (req_valid) state_nxt = S_ISSUE;
         S_ISSUE: if (last_beat) state_nxt = S_DONE;
         S_DONE:  if (rsp_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         idx    <= 4'd0;
         len_q  <= 4'd0;
         func_q <= 4'd0;
         vs1_q  <= '0;
         vs2_q  <= '0;
         vd_q   <= '0;
         mask_q <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  len_q  <= eff_len;
                  func_q <= req_func;
                  vs1_q  <= req_vs1;
                  vs2_q  <= req_vs2;
                  vd_q   <= req_vs1;
                  mask_q <= '0;
                  idx    <= 4'd0;
               end
            end
            S_ISSUE: begin
               for (int j = 0; j < LANES; j++) begin
                  if (lane_live[j]) begin
                     vd_q[{lane_elem[j], 4'b0000} +: 16] <= alu_opout[16*j +: 16];
                     mask_q[lane_elem[j]] <= ((func_q == F_CMPGT) && alu_gt[j]) ||
                                             ((func_q == F_CMPEQ) && alu_eq[j]);
                  end
               end
               idx <= idx + STEP4;
            end
            default: ;
         endcase
      end
   end

   // Lane controls are live only while issuing; pass and compares leave the ALU idle.
   always_comb begin
      alu_enable = 1'b0;
      alu_addsel = 1'b0;
      alu_subsel = 1'b0;
      alu_mulsel = 1'b0;
      alu_itfsel = 1'b0;
      alu_ftisel = 1'b0;
      alu_maxsel = 1'b0;
      alu_minsel = 1'b0;
      alu_op1    = '0;
      alu_op2    = '0;
      if (state == S_ISSUE) begin
         unique case (func_q)
            F_ADD:   begin alu_enable = 1'b1; alu_addsel = 1'b1; end
            F_SUB:   begin alu_enable = 1'b1; alu_subsel = 1'b1; end
            F_MUL:   begin alu_enable = 1'b1; alu_mulsel = 1'b1; end
            F_ITF:   begin alu_enable = 1'b1; alu_itfsel = 1'b1; end
            F_FTI:   begin alu_enable = 1'b1; alu_ftisel = 1'b1; end
            F_MAX:   begin alu_enable = 1'b1; alu_maxsel = 1'b1; end
            F_MIN:   begin alu_enable = 1'b1; alu_minsel = 1'b1; end
            default: ;
         endcase
         for (int j = 0; j < LANES; j++) begin
            alu_op1[16*j +: 16] = vs1_q[{lane_elem[j], 4'b0000} +: 16];
            alu_op2[16*j +: 16] = vs2_q[{lane_elem[j], 4'b0000} +: 16];
         end
      end
   end

   assign req_ready = (state == S_IDLE);
   assign rsp_valid = (state == S_DONE);
   assign busy      = (state == S_ISSUE) || (state == S_DONE);
   assign rsp_vd    = vd_q;
   assign rsp_mask  = mask_q;

endmodule

// File: tb/tb_vpu_lane_seq.sv
// Bench for vpu_lane_seq: adder-style ALU stub, directed scenarios, then random
// instructions checked against a per-element reference model.
module tb_vpu_lane_seq;

   localparam int LANES = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 req_valid;
   logic                 req_ready;
   logic [3:0]           req_func;
   logic [3:0]           req_len;
   logic [127:0]         req_vs1;
   logic [127:0]         req_vs2;
   logic                 alu_enable;
   logic                 alu_addsel, alu_subsel, alu_mulsel, alu_itfsel;
   logic                 alu_ftisel, alu_maxsel, alu_minsel;
   logic [16*LANES-1:0]  alu_op1;
   logic [16*LANES-1:0]  alu_op2;
   logic [16*LANES-1:0]  alu_opout;
   logic [LANES-1:0]     alu_gt;
   logic [LANES-1:0]     alu_eq;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [127:0]         rsp_vd;
   logic [7:0]           rsp_mask;
   logic                 busy;

   int total = 0;
   int bad   = 0;
   int addsel_cycles;
   logic [127:0] last_vd;
   logic [7:0]   last_mask;
   logic [135:0] exp_q[$];

   vpu_lane_seq #(.LANES(LANES)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
      .req_len(req_len), .req_vs1(req_vs1), .req_vs2(req_vs2),
      .alu_enable(alu_enable), .alu_addsel(alu_addsel), .alu_subsel(alu_subsel),
      .alu_mulsel(alu_mulsel), .alu_itfsel(alu_itfsel), .alu_ftisel(alu_ftisel),
      .alu_maxsel(alu_maxsel), .alu_minsel(alu_minsel),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opout(alu_opout),
      .alu_gt(alu_gt), .alu_eq(alu_eq),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_vd(rsp_vd),
      .rsp_mask(rsp_mask), .busy(busy)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ALU stub: wrap-add when enabled, else pass op1; unsigned compares.
   always_comb begin
      for (int j = 0; j < LANES; j++) begin
         alu_opout[16*j +: 16] = alu_enable ? (alu_op1[16*j +: 16] + alu_op2[16*j +: 16])
                                            : alu_op1[16*j +: 16];
         alu_gt[j] = alu_op1[16*j +: 16] > alu_op2[16*j +: 16];
         alu_eq[j] = alu_op1[16*j +: 16] == alu_op2[16*j +: 16];
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model
   function automatic int eff_len(input logic [3:0] len);
      return (len == 4'd0 || len > 4'd8) ? 8 : int'(len);
   endfunction

   function automatic logic [135:0] model(input logic [3:0] func, input logic [3:0] len,
                                          input logic [127:0] vs1, input logic [127:0] vs2);
      logic [127:0] vd;
      logic [7:0]   m;
      logic [15:0]  a, b;
      vd = vs1;
      m  = 8'h00;
      for (int i = 0; i < eff_len(len); i++) begin
         a = vs1[16*i +: 16];
         b = vs2[16*i +: 16];
         if (func >= 4'd1 && func <= 4'd7) vd[16*i +: 16] = a + b;
         if (func == 4'd8) m[i] = (a > b);
         if (func == 4'd9) m[i] = (a == b);
      end
      return {m, vd};
   endfunction

   function automatic logic [6:0] sel_model(input logic [3:0] func);
      logic [6:0] one;
      one = 7'b1000000;
      return (func >= 4'd1 && func <= 4'd7) ? (one >> (func - 4'd1)) : 7'b0;
   endfunction

   function automatic logic [6:0] sel_vec();
      return {alu_addsel, alu_subsel, alu_mulsel, alu_itfsel, alu_ftisel, alu_maxsel, alu_minsel};
   endfunction

   function automatic logic [127:0] alu_all();
      return 128'({alu_enable, sel_vec(), alu_op1, alu_op2});
   endfunction

   // Driver: one full instruction, with optional response backpressure and a
   // stray request pulsed while the response is held.
   task automatic run_instr(input logic [3:0] func, input logic [3:0] len,
                            input logic [127:0] vs1, input logic [127:0] vs2,
                            input int hold, input bit pulse);
      logic [135:0]        exp;
      logic [16*LANES-1:0] e1, e2;
      int n, k, cyc, issue;
      n = eff_len(len);
      k = (n + LANES - 1) / LANES;
      exp_q.push_back(model(func, len, vs1, vs2));
      check("req_ready_before", 128'(req_ready), 128'(1));
      req_valid = 1'b1;
      req_func  = func;
      req_len   = len;
      req_vs1   = vs1;
      req_vs2   = vs2;
      rsp_ready = (hold == 0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_func  = 4'($urandom);
      req_len   = 4'($urandom);
      req_vs1   = {$urandom, $urandom, $urandom, $urandom};
      req_vs2   = {$urandom, $urandom, $urandom, $urandom};
      cyc   = 1;
      issue = 0;
      while (!rsp_valid && cyc <= 40) begin
         for (int j = 0; j < LANES; j++) begin
            e1[16*j +: 16] = vs1[16*(issue*LANES + j) +: 16];
            e2[16*j +: 16] = vs2[16*(issue*LANES + j) +: 16];
         end
         check("issue_enable", 128'(alu_enable), 128'(func >= 4'd1 && func <= 4'd7));
         check("issue_selects", 128'(sel_vec()), 128'(sel_model(func)));
         check("issue_operands", 128'({alu_op1, alu_op2}), 128'({e1, e2}));
         check("issue_flags", 128'({busy, req_ready}), 128'(2'b10));
         if (alu_addsel) addsel_cycles++;
         issue++;
         @(posedge clk); #1;
         cyc++;
      end
      check("issue_cycles", 128'(issue), 128'(k));
      check("rsp_valid_cycle", 128'(cyc), 128'(k + 1));
      exp = exp_q.pop_front();
      last_vd   = rsp_vd;
      last_mask = rsp_mask;
      check("rsp_vd", rsp_vd, exp[127:0]);
      check("rsp_mask", 128'(rsp_mask), 128'(exp[135:128]));
      check("done_alu_idle", alu_all(), 128'(0));
      for (int h = 0; h < hold; h++) begin
         if (pulse && h == 3) begin
            req_valid = 1'b1;
            req_func  = 4'd1;
            req_len   = 4'd8;
            req_vs1   = {$urandom, $urandom, $urandom, $urandom};
         end
         @(posedge clk); #1;
         req_valid = 1'b0;
         check("hold_state", 128'({rsp_valid, req_ready, busy}), 128'(3'b101));
         check("hold_vd", rsp_vd, exp[127:0]);
         check("hold_mask", 128'(rsp_mask), 128'(exp[135:128]));
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("after_handshake", 128'({rsp_valid, req_ready, busy}), 128'(3'b010));
      if (pulse) begin
         @(posedge clk); #1;
         check("stray_req_ignored", 128'({req_ready, busy, alu_enable}), 128'(3'b100));
      end
   endtask

   initial begin
      logic [127:0] a, b, exp_vd;
      bit seen;
      rst = 1'b1; req_valid = 1'b0; req_func = '0; req_len = '0;
      req_vs1 = '0; req_vs2 = '0; rsp_ready = 1'b1;

      // 1: reset
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("reset_flags", 128'({req_ready, rsp_valid, busy}), 128'(3'b100));
      check("reset_alu", alu_all(), 128'(0));
      check("reset_vd", rsp_vd, 128'(0));
      check("reset_mask", 128'(rsp_mask), 128'(0));

      // 2: full-length add
      for (int i = 0; i < 8; i++) begin
         a[16*i +: 16] = 16'(i + 1);
         b[16*i +: 16] = 16'h0010;
      end
      addsel_cycles = 0;
      run_instr(4'd1, 4'd8, a, b, 0, 1'b0);
      check("add_addsel_cycles", 128'(addsel_cycles), 128'(4));
      check("add_vd_const", last_vd, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
      check("add_mask_const", 128'(last_mask), 128'(0));

      // 3: cmpgt, len 5
      a = {16'd9, 16'd9, 16'd9, 16'd2, 16'd7, 16'd3, 16'd5, 16'd1};
      b = {8{16'd3}};
      run_instr(4'd8, 4'd5, a, b, 0, 1'b0);
      check("cmpgt_mask_const", 128'(last_mask), 128'(8'h0A));
      check("cmpgt_vd_is_vs1", last_vd, a);

      // 4: sub, len 3
      a = {8{16'h3C00}};
      b = {8{16'h0001}};
      addsel_cycles = 0;
      run_instr(4'd2, 4'd3, a, b, 0, 1'b0);
      check("sub_no_addsel", 128'(addsel_cycles), 128'(0));
      check("sub_vd_const", last_vd, {{5{16'h3C00}}, {3{16'h3C01}}});

      // 5: backpressure with a stray request, then a real follow-up
      a = {$urandom, $urandom, $urandom, $urandom};
      b = {$urandom, $urandom, $urandom, $urandom};
      run_instr(4'd6, 4'd7, a, b, 10, 1'b1);
      run_instr(4'd9, 4'd0, a, a, 0, 1'b0);
      check("cmpeq_self_mask", 128'(last_mask), 128'(8'hFF));

      // 6: reset in the second issue cycle of a len-8 add
      req_valid = 1'b1; req_func = 4'd1; req_len = 4'd8;
      req_vs1 = {$urandom, $urandom, $urandom, $urandom}; req_vs2 = req_vs1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("second_issue_busy", 128'({busy, alu_addsel}), 128'(2'b11));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midreset_flags", 128'({req_ready, rsp_valid, busy}), 128'(3'b100));
      check("midreset_vd", rsp_vd, 128'(0));
      check("midreset_alu", alu_all(), 128'(0));
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (rsp_valid || busy) seen = 1'b1;
      end
      check("midreset_no_rsp", 128'(seen), 128'(0));

      // Random instructions, including out-of-range func and len codes
      for (int t = 0; t < 30; t++) begin
         for (int i = 0; i < 8; i++) begin
            a[16*i +: 16] = (t % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
            b[16*i +: 16] = (t % 2 == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
         end
         run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), a, b,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Final report
      exp_vd = 128'(exp_q.size());
      check("scoreboard_empty", exp_vd, 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vpu_lane_seq.md
# vpu_lane_seq

Vector issue sequencer for the half-precision VPU datapath. Accepts one vector instruction at a time: two 128-bit source vectors of 8 fp16 elements, a function code and an element count. Streams element pairs, LANES per cycle, into combinational FP16 ALU lanes, captures lane results and compare flags, and returns an assembled 128-bit result plus an 8-bit compare mask over a valid/ready handshake. Sits between VPU decode/register read and the FP16 ALU lanes.

## Interface
- LANES, 2, ALU lanes driven per cycle; legal values 1, 2, 4, 8.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  instruction valid.
- req_ready  out  1  high only in IDLE.
- req_func  in  4  0 pass, 1 add, 2 sub, 3 mul, 4 itf, 5 fti, 6 max, 7 min, 8 cmpgt, 9 cmpeq; 10–15 treated as pass.
- req_len  in  4  active element count 1..8; 0 means 8; 9–15 clamp to 8.
- req_vs1, req_vs2  in  128  sources; element i = bits [16i+15:16i].
- alu_enable  out  1  shared lane enable.
- alu_addsel, alu_subsel, alu_mulsel, alu_itfsel, alu_ftisel, alu_maxsel, alu_minsel  out  1 each  shared one-hot selects.
- alu_op1, alu_op2  out  16*LANES  lane j = bits [16j+15:16j].
- alu_opout  in  16*LANES  lane results.
- alu_gt, alu_eq  in  LANES  lane compare flags.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_vd  out  128  result vector.
- rsp_mask  out  8  compare mask; bit i for element i.
- busy  out  1  high in ISSUE or DONE.

ALU vec_en and ftlsel are tied low outside this block.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE: req_ready=1. On req_valid, latch vs1, vs2, func and effective len (N). Load rsp_vd with vs1 and clear rsp_mask. Set idx=0, go to ISSUE.
- ISSUE: lane j drives op1 = vs1[idx+j] and op2 = vs2[idx+j].
  - Selects by func: add→addsel; sub→subsel only; mul→mulsel; itf→itfsel; fti→ftisel; max→maxsel; min→minsel. alu_enable=1 for funcs 1–7.
  - For pass and compare funcs, alu_enable=0 and all selects are 0.
- Capture at the end of each ISSUE cycle, for each lane with idx+j < N:
  - rsp_vd element idx+j ← alu_opout lane j.
  - rsp_mask bit idx+j ← alu_gt[j] (cmpgt), alu_eq[j] (cmpeq), else 0.
- Elements ≥ N are never written: they keep the vs1 value, mask bit 0. Lanes beyond N still drive operands; their results are ignored.
- idx += LANES each cycle. When idx+LANES ≥ N, go to DONE.
- DONE: rsp_valid=1; rsp_vd and rsp_mask hold stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE.
- Outside ISSUE, all alu_* outputs are 0.
- idx is 4 bits; it never exceeds 8.

## Timing
- Reset, from the first clk edge with rst=1: state IDLE, idx=0, all latches 0.
  - Output reset values: req_ready=1, rsp_valid=0, busy=0, rsp_vd=0, rsp_mask=0, all alu_* 0.
- rst overrides every state. An in-flight instruction is discarded and no response is produced.
- Accept edge = cycle 0. ISSUE occupies cycles 1..K, with K = ceil(N/LANES). rsp_valid rises in cycle K+1.
- With rsp_ready held high, req_ready returns in cycle K+2. Throughput is one instruction per K+2 cycles.
- The ALU is combinational: lane results are sampled on the same edge that ends their issue cycle. There is no ALU pipeline stage.
- rsp_ready low in DONE: hold indefinitely, no output change.
- req_valid outside IDLE is ignored; req_* need not stay stable after acceptance.

## Test plan
Bench ALU stub: opout = enable ? op1+op2 (16-bit wrap) : op1; gt = op1>op2 unsigned; eq = op1==op2.

1. Reset with rst=1 for 2 cycles, then release → req_ready=1, rsp_valid=0, busy=0, all alu_* 0.
2. func=1, len=8, LANES=2, vs1 elements 0x0001..0x0008, vs2 all 0x0010.
   - Expect alu_addsel=1 for exactly 4 cycles and rsp_valid in cycle 5.
   - Expect rsp_vd elements 0x0011..0x0018, rsp_mask=0x00.
3. func=8, len=5, vs1 = {1,5,3,7,2,9,9,9}, vs2 all 3.
   - Expect alu_enable=0 and 3 ISSUE cycles.
   - Expect rsp_mask=0x0A, rsp_vd=vs1, mask bits 5–7 = 0.
4. func=2, len=3, vs1 all 0x3C00, vs2 all 0x0001.
   - Expect alu_subsel=1, alu_addsel=0.
   - Expect elements 0–2 = stub result 0x3C01, elements 3–7 = 0x3C00.
5. Backpressure: rsp_ready=0 for 10 cycles after rsp_valid, with a second req_valid pulsed meanwhile.
   - Expect rsp_vd stable, req_ready=0, second request not accepted until the cycle after the handshake.
6. rst=1 in the second ISSUE cycle of a len=8 add → next cycle IDLE, rsp_valid never asserted, rsp_vd=0.
